seven_segment_capture: RTL and testbench

- Receive-side counterpart of the multiplexed PMOD seven-segment driver: samples the digit-select line (anodeSel) and the 7-bit segment bus, then recovers the hex nibble shown on each of the two digits.
- Used for on-board loopback checking and as a monitor in system benches.
- Outputs debounced, decoded digits, blank flags, an update strobe and error/lost-signal indicators.

---
 rtl/seven_segment_capture.sv | 178 +++++++++++++++++
 tb/tb_seven_segment_capture.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_capture.sv
// Recovers the two hex digits shown on a multiplexed seven-segment bus.
// Optional SEGCAP_STATS_EN adds saturating frame_count / err_count outputs.
module seven_segment_capture #(
  parameter int unsigned CLK_PER        = 10,
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned STABLE_FRAMES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned SEG_ACTIVE_LOW = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            anodeSel,
  input  logic [6:0]      cathode,
  output logic [1:0][3:0] encoded,
  output logic [1:0]      blank,
  output logic            valid,
  output logic            update,
  output logic            bad_pattern,
  output logic            lost
`ifdef SEGCAP_STATS_EN
  ,
  output logic [15:0]     frame_count,
  output logic [15:0]     err_count
`endif
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned MW = $clog2(STABLE_FRAMES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  if (SETTLE_CYCLES < 1 || STABLE_FRAMES < 1 || CLK_PER < 1) begin : g_bad_param
    $error("seven_segment_capture: invalid parameter");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_HOLD} state_t;

  state_t         state, state_nxt;
  logic           anode_s1, anode_s2, anode_prev;
  logic [6:0]     cath_s1, cath_s2, cath_prev;
  logic [SW-1:0]  settle_cnt;
  logic [TW-1:0]  tmo_cnt;
  logic [6:0]     cand [2];
  logic [MW-1:0]  match_cnt [2];
  logic [1:0]     loaded;

  logic           edge_c, dig_c, same_c, ok_c, blank_c, load_c, changed_c;
  logic [6:0]     seg_c;
  logic [3:0]     nib_c;
  logic [MW-1:0]  cnt_nxt_c;

  // Table lookup: {ok, blank, nibble}
  function automatic logic [5:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h3F: return 6'h20; 7'h06: return 6'h21; 7'h5B: return 6'h22; 7'h4F: return 6'h23;
      7'h66: return 6'h24; 7'h6D: return 6'h25; 7'h7D: return 6'h26; 7'h07: return 6'h27;
      7'h7F: return 6'h28; 7'h6F: return 6'h29; 7'h77: return 6'h2A; 7'h7C: return 6'h2B;
      7'h39: return 6'h2C; 7'h5E: return 6'h2D; 7'h79: return 6'h2E; 7'h71: return 6'h2F;
      7'h00: return 6'h30;
      default: return 6'h00;
    endcase
  endfunction

  // Input synchronisers plus one aligned stage used for edge detect and sampling
  always_ff @(posedge clk) begin
    if (reset) begin
      anode_s1   <= 1'b0;
      anode_s2   <= 1'b0;
      anode_prev <= 1'b0;
      cath_s1    <= 7'd0;
      cath_s2    <= 7'd0;
      cath_prev  <= 7'd0;
    end else begin
      anode_s1   <= anodeSel;
      anode_s2   <= anode_s1;
      anode_prev <= anode_s2;
      cath_s1    <= cathode;
      cath_s2    <= cath_s1;
      cath_prev  <= cath_s2;
    end
  end

  assign edge_c = anode_s2 ^ anode_prev;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (edge_c) state_nxt = S_SETTLE;
      S_SETTLE: if (!edge_c && settle_cnt == SW'(SETTLE_CYCLES - 1)) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = edge_c ? S_SETTLE : S_HOLD;
      S_HOLD:   if (edge_c) state_nxt = S_SETTLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Settle timer restarts on any edge so glitches push the sample point out
  always_ff @(posedge clk) begin
    if (reset || state != S_SETTLE || edge_c) settle_cnt <= '0;
    else                                       settle_cnt <= settle_cnt + SW'(1);
  end

  // Sample datapath: the prev stage still holds the settled digit if an edge lands in SAMPLE
  always_comb begin
    seg_c     = (SEG_ACTIVE_LOW != 0) ? ~cath_prev : cath_prev;
    dig_c     = ~anode_prev;
    {ok_c, blank_c, nib_c} = seg_decode(seg_c);
    same_c    = (seg_c == cand[dig_c]);
    cnt_nxt_c = MW'(1);
    if (!ok_c)
      cnt_nxt_c = '0;
    else if (same_c)
      cnt_nxt_c = (match_cnt[dig_c] == MW'(STABLE_FRAMES)) ? match_cnt[dig_c]
                                                            : match_cnt[dig_c] + MW'(1);
    load_c    = (state == S_SAMPLE) && ok_c && !lost && (cnt_nxt_c == MW'(STABLE_FRAMES));
    changed_c = ({blank_c, nib_c} != {blank[dig_c], encoded[dig_c]});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand[0]      <= 7'd0;
      cand[1]      <= 7'd0;
      match_cnt[0] <= '0;
      match_cnt[1] <= '0;
      loaded       <= 2'b00;
      encoded      <= '0;
      blank        <= 2'b00;
      valid        <= 1'b0;
      update       <= 1'b0;
      bad_pattern  <= 1'b0;
    end else begin
      update      <= 1'b0;
      bad_pattern <= 1'b0;
      if (state == S_SAMPLE) begin
        bad_pattern      <= ~ok_c;
        match_cnt[dig_c] <= cnt_nxt_c;
        if (ok_c && !same_c) cand[dig_c] <= seg_c;
        if (load_c) begin
          encoded[dig_c] <= nib_c;
          blank[dig_c]   <= blank_c;
          loaded[dig_c]  <= 1'b1;
          update         <= changed_c;
          if (loaded[~dig_c]) valid <= 1'b1;
        end
      end
    end
  end

  // Loss-of-signal watchdog
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
      lost    <= 1'b0;
    end else if (edge_c) begin
      tmo_cnt <= '0;
      lost    <= 1'b0;
    end else begin
      if (tmo_cnt != TW'(TIMEOUT_CYCLES)) tmo_cnt <= tmo_cnt + TW'(1);
      lost <= (tmo_cnt == TW'(TIMEOUT_CYCLES));
    end
  end

`ifdef SEGCAP_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= 16'd0;
      err_count   <= 16'd0;
    end else if (state == S_SAMPLE) begin
      if (frame_count != 16'hFFFF)        frame_count <= frame_count + 16'd1;
      if (!ok_c && err_count != 16'hFFFF) err_count   <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seven_segment_capture.sv
// Randomised and directed checks of seven_segment_capture against a frame-level model.
module tb_seven_segment_capture;

  localparam int unsigned SF  = 2;
  localparam int unsigned TMO = 50;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            anode_sel = 1'b0;
  logic [6:0]      cathode = 7'd0;
  logic [1:0][3:0] encoded;
  logic [1:0]      blank;
  logic            valid, update, bad_pattern, lost;
`ifdef SEGCAP_STATS_EN
  logic [15:0]     frame_count, err_count;
`endif

  seven_segment_capture #(
    .CLK_PER(10), .SETTLE_CYCLES(8), .STABLE_FRAMES(SF),
    .TIMEOUT_CYCLES(TMO), .SEG_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .reset(reset), .anodeSel(anode_sel), .cathode(cathode),
    .encoded(encoded), .blank(blank), .valid(valid), .update(update),
    .bad_pattern(bad_pattern), .lost(lost)
`ifdef SEGCAP_STATS_EN
    , .frame_count(frame_count), .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Pulse monitors
  int upd_seen = 0, bad_seen = 0, blank1_seen = 0;
  always @(negedge clk) begin
    if (update === 1'b1)      upd_seen++;
    if (bad_pattern === 1'b1) bad_seen++;
    if (blank[1] === 1'b1)    blank1_seen++;
  end

  // Frame-level reference model
  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [6:0] m_cand [2];
  int         m_cnt [2];
  logic [3:0] m_enc [2];
  logic       m_blk [2];
  logic       m_loaded [2];
  logic       m_valid;
  int         exp_upd = 0, exp_bad = 0, exp_frames = 0, exp_err = 0;

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cand[i] = 7'd0; m_cnt[i] = 0; m_enc[i] = 4'd0; m_blk[i] = 1'b0; m_loaded[i] = 1'b0;
    end
    m_valid = 1'b0; exp_frames = 0; exp_err = 0;
  endfunction

  function automatic void model_sample(input int d, input logic [6:0] p);
    bit ok = 0, bl = 0;
    logic [3:0] nib = 4'd0;
    if (p == 7'h00) begin ok = 1; bl = 1; end
    for (int i = 0; i < 16; i++) if (tbl[i] == p) begin ok = 1; nib = 4'(i); end
    if (exp_frames < 65535) exp_frames++;
    if (!ok) begin
      exp_bad++;
      if (exp_err < 65535) exp_err++;
      m_cnt[d] = 0;
      return;
    end
    if (p == m_cand[d]) m_cnt[d] = (m_cnt[d] + 1 > SF) ? SF : m_cnt[d] + 1;
    else begin m_cand[d] = p; m_cnt[d] = 1; end
    if (m_cnt[d] == SF) begin
      if (nib != m_enc[d] || bl != m_blk[d]) exp_upd++;
      m_enc[d] = nib; m_blk[d] = bl;
      if (m_loaded[1-d]) m_valid = 1'b1;
      m_loaded[d] = 1'b1;
    end
  endfunction

  task automatic drive_frame(input logic a, input logic [6:0] p, input int len);
    @(posedge clk); #1;
    anode_sel = a; cathode = p;
    repeat (len) @(posedge clk);
    model_sample(a ? 0 : 1, p);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; anode_sel = 1'b0; cathode = 7'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({encoded, blank, valid, update, bad_pattern, lost} !== 14'd0) begin
      errors++;
      $display("FAIL reset_state: got enc=%h blank=%b valid=%b upd=%b bad=%b lost=%b, want all 0",
               encoded, blank, valid, update, bad_pattern, lost);
    end
    @(posedge clk); #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    int u0 = upd_seen, b0 = bad_seen;
    for (int i = 0; i < 3; i++) begin
      drive_frame(1'b1, 7'h4F, 1000);
      drive_frame(1'b0, 7'h77, 1000);
    end
    checks++;
    if (encoded !== 8'hA3) begin errors++; $display("FAIL basic_encoded: got %h want a3", encoded); end
    checks++;
    if (valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", valid); end
    checks++;
    if (upd_seen - u0 != 2) begin errors++; $display("FAIL basic_update_count: got %0d want 2", upd_seen - u0); end
    checks++;
    if (bad_seen - b0 != 0 || blank !== 2'b00) begin
      errors++; $display("FAIL basic_clean: got bad=%0d blank=%b want 0 00", bad_seen - b0, blank);
    end
  endtask

  task automatic test_glitch();
    int u0 = upd_seen, b0 = bad_seen;
    @(posedge clk); #1 anode_sel = 1'b1; cathode = 7'h4F;
    repeat (3) @(posedge clk); #1 anode_sel = 1'b0; cathode = 7'h49;
    @(posedge clk); #1 anode_sel = 1'b1; cathode = 7'h4F;
    repeat (30) @(posedge clk);
    model_sample(0, 7'h4F);
    @(negedge clk);
    checks++;
    if (bad_seen - b0 != 0) begin errors++; $display("FAIL glitch_bad: got %0d pulses want 0", bad_seen - b0); end
    checks++;
    if (encoded !== 8'hA3 || upd_seen - u0 != 0) begin
      errors++; $display("FAIL glitch_hold: got enc=%h upd=%0d want a3 0", encoded, upd_seen - u0);
    end
  endtask

  task automatic test_bad_pattern();
    int b0 = bad_seen;
    for (int i = 0; i < 3; i++) begin
      drive_frame(1'b0, 7'h77, 20);
      drive_frame(1'b1, 7'h49, 20);
    end
    checks++;
    if (bad_seen - b0 != 3) begin errors++; $display("FAIL bad_count: got %0d want 3", bad_seen - b0); end
    checks++;
    if (encoded[0] !== 4'h3 || encoded !== {m_enc[1], m_enc[0]}) begin
      errors++; $display("FAIL bad_hold: got %h want %h%h", encoded, m_enc[1], m_enc[0]);
    end
  endtask

  task automatic test_blank_stability();
    int u0 = upd_seen, s0 = blank1_seen;
    drive_frame(1'b0, 7'h00, 20);
    drive_frame(1'b1, 7'h4F, 20);
    drive_frame(1'b0, 7'h06, 20);
    drive_frame(1'b1, 7'h4F, 20);
    checks++;
    if (encoded[1] !== 4'hA) begin errors++; $display("FAIL stable_early: got %h want a", encoded[1]); end
    drive_frame(1'b0, 7'h06, 20);
    checks++;
    if (blank1_seen - s0 != 0) begin errors++; $display("FAIL blank1_set: got %0d cycles want 0", blank1_seen - s0); end
    checks++;
    if (encoded !== 8'h13) begin errors++; $display("FAIL stable_encoded: got %h want 13", encoded); end
    checks++;
    if (upd_seen - u0 != 1) begin errors++; $display("FAIL stable_update: got %0d want 1", upd_seen - u0); end
  endtask

  task automatic test_timeout();
    drive_frame(1'b1, 7'h4F, 40);
    checks++;
    if (lost !== 1'b0) begin errors++; $display("FAIL lost_early: got %b want 0", lost); end
    repeat (25) @(posedge clk);
    @(negedge clk);
    checks++;
    if (lost !== 1'b1) begin errors++; $display("FAIL lost_set: got %b want 1", lost); end
    checks++;
    if (encoded !== 8'h13 || blank !== 2'b00) begin
      errors++; $display("FAIL lost_hold: got enc=%h blank=%b want 13 00", encoded, blank);
    end
    @(posedge clk); #1 anode_sel = 1'b0; cathode = 7'h06;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (lost !== 1'b0) begin errors++; $display("FAIL lost_clear: got %b want 0", lost); end
    repeat (20) @(posedge clk);
    model_sample(1, 7'h06);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1 anode_sel = 1'b1; cathode = 7'h7D;
    repeat (5) @(posedge clk); #1;
    reset = 1'b1; anode_sel = 1'b0; cathode = 7'd0;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({encoded, blank, valid, update, bad_pattern, lost} !== 14'd0) begin
      errors++; $display("FAIL midreset_state: got enc=%h blank=%b valid=%b upd=%b bad=%b lost=%b, want all 0",
                         encoded, blank, valid, update, bad_pattern, lost);
    end
    @(posedge clk); #1 reset = 1'b0;
    model_reset();
    drive_frame(1'b1, 7'h4F, 20);
    drive_frame(1'b0, 7'h77, 20);
    drive_frame(1'b1, 7'h4F, 20);
    checks++;
    if (valid !== 1'b0 || encoded !== 8'h03) begin
      errors++; $display("FAIL midreset_partial: got valid=%b enc=%h want 0 03", valid, encoded);
    end
    drive_frame(1'b0, 7'h77, 20);
    checks++;
    if (valid !== 1'b1 || encoded !== 8'hA3) begin
      errors++; $display("FAIL midreset_resume: got valid=%b enc=%h want 1 a3", valid, encoded);
    end
  endtask

  function automatic logic [6:0] pick_pattern();
    int r = $urandom_range(0, 99);
    if (r < 70) return tbl[$urandom_range(0, 15)];
    if (r < 85) return 7'h00;
    return 7'($urandom);
  endfunction

  task automatic test_random();
    logic [6:0] last [2];
    logic [6:0] p;
    last[0] = 7'h4F; last[1] = 7'h77;
    for (int f = 0; f < 40; f++) begin
      int d = f % 2;
      p = ($urandom_range(0, 99) < 60) ? last[d] : pick_pattern();
      last[d] = p;
      drive_frame(d == 0, p, $urandom_range(16, 30));
      checks++;
      if (encoded !== {m_enc[1], m_enc[0]} || blank !== {m_blk[1], m_blk[0]} || valid !== m_valid) begin
        errors++; $display("FAIL rand_out[%0d]: got enc=%h blank=%b valid=%b want %h%h %b%b %b",
                           f, encoded, blank, valid, m_enc[1], m_enc[0], m_blk[1], m_blk[0], m_valid);
      end
      checks++;
      if (upd_seen != exp_upd || bad_seen != exp_bad) begin
        errors++; $display("FAIL rand_pulses[%0d]: got upd=%0d bad=%0d want %0d %0d",
                           f, upd_seen, bad_seen, exp_upd, exp_bad);
      end
    end
  endtask

  task automatic test_stats();
`ifdef SEGCAP_STATS_EN
    checks++;
    if (frame_count !== 16'(exp_frames) || err_count !== 16'(exp_err)) begin
      errors++; $display("FAIL stats: got frames=%0d errs=%0d want %0d %0d",
                         frame_count, err_count, exp_frames, exp_err);
    end
`endif
  endtask

  task automatic test_bad_stats();
`ifdef SEGCAP_STATS_EN
    int e0 = exp_err;
    logic [15:0] c0 = err_count;
    drive_frame(1'b0, 7'h77, 20);
    drive_frame(1'b1, 7'h49, 20);
    drive_frame(1'b0, 7'h77, 20);
    drive_frame(1'b1, 7'h49, 20);
    drive_frame(1'b0, 7'h77, 20);
    drive_frame(1'b1, 7'h49, 20);
    checks++;
    if (err_count - c0 !== 16'd3 || exp_err - e0 != 3) begin
      errors++; $display("FAIL err_count_delta: got %0d want 3", err_count - c0);
    end
    drive_frame(1'b0, 7'h77, 20);
    drive_frame(1'b1, 7'h4F, 20);
    drive_frame(1'b1 ^ 1'b1, 7'h77, 20);
    drive_frame(1'b1, 7'h4F, 20);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_bad_pattern();
    test_blank_stability();
    test_timeout();
    test_reset_mid();
    test_random();
    test_stats();
    test_bad_stats();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
